// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game controller.
// Holds the state encoding (the 7-segment debug display decodes these codes)
// and the default per-play response timeout.
package jogo_pkg;

    // State codes are exported on db_estado, so the values are fixed.
    typedef enum logic [3:0] {
        Inicial    = 4'h0,
        Prepara    = 4'h1,
        NovaSeq    = 4'h2,
        Espera     = 4'h3,
        Registra   = 4'h4,
        Compara    = 4'h5,
        ProxJogada = 4'h6,
        ProxSeq    = 4'h7,
        FimAcerto  = 4'hA,
        FimTimeout = 4'hD,
        FimErro    = 4'hE
    } estado_e;

    localparam int unsigned TimeoutDefault = 3000;
    localparam int unsigned TwDefault      = 12;

endpackage

// File: rtl/contador_timeout.sv
// Per-play response timer.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low; clears the count
//   clear  - synchronous clear (held while the FSM is outside ESPERA)
//   enable - count one step per cycle
//   fim    - count has reached TIMEOUT-1 (never asserted when TIMEOUT == 0)
// The count saturates at TIMEOUT-1 instead of wrapping.
module contador_timeout
    import jogo_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned TW      = TwDefault
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    // With the timeout disabled the limit collapses to 0, which also holds the count at 0.
    localparam logic [TW-1:0] Limite = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != Limite)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (TIMEOUT != 0) && (cnt_q == Limite);

endmodule

// File: rtl/unidade_controle_sequencia.sv
// Moore control unit for the growing-sequence memory game.
// Round k replays addresses 0..k; each play must match memory before the timeout.
// Ports:
//   clock, reset                     - clock (rising edge), async active-low reset
//   iniciar                          - start/restart request (level)
//   tem_jogada                       - one-cycle pulse, new play available
//   jogadaIgualMemoria               - play register equals memory at current address
//   enderecoIgualSequencia           - address counter equals sequence limit
//   fimS                             - sequence limit is at its last round
//   zeraE/contaE, zeraS/contaS       - address / sequence-limit counter controls
//   zeraR/registraR                  - play register controls
//   pronto, ganhou, perdeu           - end-of-game flags
//   db_timeout                       - loss caused by timeout
//   db_estado                        - current state code for the debug display
module unidade_controle_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned TW      = TwDefault
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       fimS,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_e estado_q, estado_d;
    logic    timer_fim;

    contador_timeout #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado_q != Espera),
        .enable (estado_q == Espera),
        .fim    (timer_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= Inicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            Inicial:    if (iniciar) estado_d = Prepara;
            Prepara:    estado_d = NovaSeq;
            NovaSeq:    estado_d = Espera;
            Espera: begin
                // A play on the same edge as the timeout wins.
                if (tem_jogada) begin
                    estado_d = Registra;
                end else if (timer_fim) begin
                    estado_d = FimTimeout;
                end
            end
            Registra:   estado_d = Compara;
            Compara: begin
                if (!jogadaIgualMemoria) begin
                    estado_d = FimErro;
                end else if (!enderecoIgualSequencia) begin
                    estado_d = ProxJogada;
                end else if (fimS) begin
                    estado_d = FimAcerto;
                end else begin
                    estado_d = ProxSeq;
                end
            end
            ProxJogada: estado_d = Espera;
            ProxSeq:    estado_d = NovaSeq;
            FimAcerto, FimErro, FimTimeout: begin
                if (iniciar) estado_d = Prepara;
            end
            default:    estado_d = Inicial;
        endcase
    end

    // Moore outputs, decoded from the state register only
    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraS      = 1'b0;
        contaS     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        case (estado_q)
            Prepara: begin
                zeraE = 1'b1;
                zeraS = 1'b1;
                zeraR = 1'b1;
            end
            NovaSeq:    zeraE = 1'b1;
            Registra:   registraR = 1'b1;
            ProxJogada: contaE = 1'b1;
            ProxSeq:    contaS = 1'b1;
            FimAcerto: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FimErro: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FimTimeout: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// Bench for unidade_controle_sequencia: one instance with TIMEOUT=8 and one
// with the timeout disabled, sharing stimulus but with separate resets.
module tb_unidade_controle_sequencia;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a, rst_b, sel_b;
    logic iniciar, tem_jogada, jogada_ok, end_ok, fim_s;

    logic a_ze, a_ce, a_zs, a_cs, a_zr, a_rr, a_pr, a_g, a_p, a_t;
    logic b_ze, b_ce, b_zs, b_cs, b_zr, b_rr, b_pr, b_g, b_p, b_t;
    logic [3:0] a_est, b_est;

    unidade_controle_sequencia #(.TIMEOUT(8), .TW(12)) dut_a (
        .clock                  (clock),
        .reset                  (rst_a),
        .iniciar                (iniciar),
        .tem_jogada             (tem_jogada),
        .jogadaIgualMemoria     (jogada_ok),
        .enderecoIgualSequencia (end_ok),
        .fimS                   (fim_s),
        .zeraE                  (a_ze),
        .contaE                 (a_ce),
        .zeraS                  (a_zs),
        .contaS                 (a_cs),
        .zeraR                  (a_zr),
        .registraR              (a_rr),
        .pronto                 (a_pr),
        .ganhou                 (a_g),
        .perdeu                 (a_p),
        .db_timeout             (a_t),
        .db_estado              (a_est)
    );

    unidade_controle_sequencia #(.TIMEOUT(0), .TW(12)) dut_b (
        .clock                  (clock),
        .reset                  (rst_b),
        .iniciar                (iniciar),
        .tem_jogada             (tem_jogada),
        .jogadaIgualMemoria     (jogada_ok),
        .enderecoIgualSequencia (end_ok),
        .fimS                   (fim_s),
        .zeraE                  (b_ze),
        .contaE                 (b_ce),
        .zeraS                  (b_zs),
        .contaS                 (b_cs),
        .zeraR                  (b_zr),
        .registraR              (b_rr),
        .pronto                 (b_pr),
        .ganhou                 (b_g),
        .perdeu                 (b_p),
        .db_timeout             (b_t),
        .db_estado              (b_est)
    );

    logic [13:0] saida_a, saida_b, obs;
    assign saida_a = {a_est, a_ze, a_ce, a_zs, a_cs, a_zr, a_rr, a_pr, a_g, a_p, a_t};
    assign saida_b = {b_est, b_ze, b_ce, b_zs, b_cs, b_zr, b_rr, b_pr, b_g, b_p, b_t};
    assign obs     = sel_b ? saida_b : saida_a;

    logic [3:0] fila[$];
    int n_testes = 0;
    int n_falhas = 0;

    // Expected outputs for a state code:
    // {estado, zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, ganhou, perdeu, db_timeout}
    function automatic logic [13:0] modelo(input logic [3:0] est);
        logic [9:0] o;
        o = '0;
        case (est)
            4'h1: o = 10'b1010100000;
            4'h2: o = 10'b1000000000;
            4'h4: o = 10'b0000010000;
            4'h6: o = 10'b0100000000;
            4'h7: o = 10'b0001000000;
            4'hA: o = 10'b0000001100;
            4'hE: o = 10'b0000001010;
            4'hD: o = 10'b0000001011;
            default: o = '0;
        endcase
        return {est, o};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_testes++;
        if (got !== exp) begin
            n_falhas++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic confere(input string tag);
        logic [3:0] e;
        if (fila.size() == 0) begin
            n_testes++;
            n_falhas++;
            $display("FAIL %s: got no expectation expected a queued state", tag);
        end else begin
            e = fila.pop_front();
            check_eq(tag, obs, modelo(e));
        end
    endtask

    task automatic passo(input string tag, input logic [3:0] est);
        fila.push_back(est);
        @(posedge clock);
        #1;
        confere(tag);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; sel_b = 1'b0;
        iniciar = 1'b0; tem_jogada = 1'b0; jogada_ok = 1'b0; end_ok = 1'b0; fim_s = 1'b0;
        @(posedge clock);
        #1;
        fila.push_back(4'h0);
        confere("reset");
        rst_a = 1'b1;
        passo("idle", 4'h0);

        // Start, then asynchronous reset in the middle of ESPERA
        iniciar = 1'b1; passo("prepara", 4'h1);
        iniciar = 1'b0; passo("nova_seq", 4'h2);
        passo("espera", 4'h3);
        passo("espera_hold", 4'h3);
        fila.push_back(4'h0);
        rst_a = 1'b0;
        #1;
        confere("rst_async");
        #1;
        rst_a = 1'b1;
        passo("pos_rst", 4'h0);

        // Full win: round 0 then round 1 (last round)
        iniciar = 1'b1; passo("w_prepara", 4'h1);
        iniciar = 1'b0; passo("w_nova", 4'h2);
        passo("w_espera0", 4'h3);
        jogada_ok = 1'b1; end_ok = 1'b1; fim_s = 1'b0; tem_jogada = 1'b1;
        passo("w_reg0", 4'h4);
        tem_jogada = 1'b0; passo("w_cmp0", 4'h5);
        passo("w_prox_seq", 4'h7);
        passo("w_nova1", 4'h2);
        passo("w_espera1", 4'h3);
        fim_s = 1'b1; end_ok = 1'b0; tem_jogada = 1'b1;
        passo("w_reg1a", 4'h4);
        tem_jogada = 1'b0; passo("w_cmp1a", 4'h5);
        passo("w_prox_jog", 4'h6);
        passo("w_espera1b", 4'h3);
        end_ok = 1'b1; tem_jogada = 1'b1;
        passo("w_reg1b", 4'h4);
        tem_jogada = 1'b0; passo("w_cmp1b", 4'h5);
        passo("w_acerto", 4'hA);
        tem_jogada = 1'b1; passo("w_stray", 4'hA);
        tem_jogada = 1'b0; passo("w_hold", 4'hA);

        // Wrong play on the second play; iniciar ignored inside ESPERA
        iniciar = 1'b1; passo("e_prepara", 4'h1);
        iniciar = 1'b0; passo("e_nova", 4'h2);
        passo("e_espera", 4'h3);
        iniciar = 1'b1; passo("e_ini_ign", 4'h3);
        iniciar = 1'b0;
        jogada_ok = 1'b1; end_ok = 1'b0; tem_jogada = 1'b1;
        passo("e_reg0", 4'h4);
        tem_jogada = 1'b0; passo("e_cmp0", 4'h5);
        passo("e_prox_jog", 4'h6);
        passo("e_espera1", 4'h3);
        jogada_ok = 1'b0; tem_jogada = 1'b1;
        passo("e_reg1", 4'h4);
        tem_jogada = 1'b0; passo("e_cmp1", 4'h5);
        passo("e_erro", 4'hE);
        passo("e_hold", 4'hE);
        iniciar = 1'b1; passo("e_restart", 4'h1);
        iniciar = 1'b0; passo("t_nova", 4'h2);

        // Timeout: ESPERA entered on this edge, FIM_TIMEOUT exactly 8 edges later
        passo("t_espera", 4'h3);
        jogada_ok = 1'b1;
        for (int i = 0; i < 7; i++) passo("t_wait", 4'h3);
        passo("t_timeout", 4'hD);
        passo("t_hold", 4'hD);
        iniciar = 1'b1; passo("p_prepara", 4'h1);
        iniciar = 1'b0; passo("p_nova", 4'h2);
        passo("p_espera", 4'h3);
        for (int i = 0; i < 7; i++) passo("p_wait", 4'h3);
        tem_jogada = 1'b1; passo("p_priority", 4'h4);
        tem_jogada = 1'b0; passo("p_cmp", 4'h5);
        end_ok = 1'b0; passo("p_prox_jog", 4'h6);
        passo("p_espera1", 4'h3);

        // Timeout disabled: long idle in ESPERA
        rst_a = 1'b0;
        sel_b = 1'b1;
        #1;
        rst_b = 1'b1;
        passo("b_idle", 4'h0);
        iniciar = 1'b1; passo("b_prepara", 4'h1);
        iniciar = 1'b0; passo("b_nova", 4'h2);
        passo("b_espera", 4'h3);
        for (int i = 0; i < 1000; i++) passo("b_no_timeout", 4'h3);

        if (fila.size() != 0) begin
            n_testes++;
            n_falhas++;
            $display("FAIL sb_drain: got %0d leftover expected 0", fila.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
